dm_block_mover: RTL and testbench
=================================

# dm_block_mover

Bus-master sequencer that drives the data-memory port from the initiator side: on a start pulse it reads `len` consecutive words from the data memory starting at `src_addr` and writes them, in ascending order, to consecutive words starting at `dst_addr`. It sits between the halftone control logic and the data memory, replacing CPU-driven load/store loops for pixel-buffer moves. When compiled with the threshold option, it converts grayscale pixels to binary halftone values during the move.

## Interface
- ADDR_W, 16, data-memory word-address width.
- DATA_W, 32, data-memory word width.
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high; clock clk.
- start  in  1  launch request; sampled only in IDLE.
- abort  in  1  cancel an in-flight move.
- src_addr  in  ADDR_W  first source word address; captured at start.
- dst_addr  in  ADDR_W  first destination word address; captured at start.
- len  in  ADDR_W+1  word count, 0..2^ADDR_W; captured at start.
- threshold  in  8  pixel threshold; used only with THRESHOLD_EN.
- busy  out  1  high in READ and WRITE.
- done  out  1  one-cycle pulse on normal completion.
- dm_read  out  1  memory read enable.
- dm_write  out  1  memory write enable.
- dm_address  out  ADDR_W  memory word address.
- dm_wdata  out  DATA_W  memory write data.
- dm_rdata  in  DATA_W  memory read data, combinationally valid in the cycle dm_read=1.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: all memory outputs 0. If start=1 and abort=0, capture src/dst/len and clear word counter i. If len==0, go to DONE; otherwise go to READ.
- READ: dm_read=1, dm_address=src+i. Latch dm_rdata into the data register at the end of the cycle. Go to WRITE.
- WRITE: dm_write=1, dm_address=dst+i, dm_wdata=f(data register). Increment i. If i+1==len, go to DONE; otherwise go to READ.
- DONE: done=1. Go to IDLE.
- abort=1 in READ or WRITE: go to IDLE next cycle with no done pulse. The memory access asserted in the abort cycle still occurs. abort has priority over start in IDLE.
- start while not in IDLE is ignored.
- Address arithmetic is modulo 2^ADDR_W. src+i and dst+i wrap silently.
- Overlap: semantics are strictly sequential and ascending. If dst is in (src, src+len), already-written words are re-read. This is the defined behaviour, not an error.
- dm_read and dm_write are never both high.

## Timing
- Reset: state=IDLE and i=0. busy, done, dm_read, dm_write, dm_address and dm_wdata are all 0. No memory access occurs in any cycle with rst=1.
- rst mid-operation: the move is abandoned with no done pulse. The destination holds only the words already written.
- Latency: with start sampled at edge 0, the READ of word k occupies cycle 2k+1 and the WRITE of word k occupies cycle 2k+2. done is high in cycle 2·len+1.
- len==0: done is high in cycle 1, with no access.
- Throughput: one word per 2 cycles.
- A new start is accepted in the first cycle after DONE.
- All outputs decode from registered state, counter and data; no combinational path runs from start.

## Configuration
- THRESHOLD_EN defined: f(x) = 32'h000000FF if x[7:0] >= threshold, else 32'h00000000 (unsigned compare).
- THRESHOLD_EN undefined: f(x)=x verbatim, the threshold port is unused, and the compare logic is absent.

## Structure
- Shared package halftone_pkg holds:
  - the state enum (IDLE/READ/WRITE/DONE);
  - ADDR_W and DATA_W defaults;
  - ZERO_WORD;
  - PIX_ON=32'h000000FF and PIX_OFF=32'h0.
- One natural sub-module: halftone_thresh, the combinational pixel-to-binary map. It is instantiated only under THRESHOLD_EN.

## Test plan
- Plain copy: mem[0x10..0x13]={1,2,3,4}, src=0x10, dst=0x40, len=4 → mem[0x40..0x43]={1,2,3,4}, done in cycle 9, busy high in cycles 1–8.
- len=0, start → done in cycle 1, dm_read and dm_write never high, memory unchanged.
- Wrap: ADDR_W=16, src=0xFFFF, dst=0x0100, len=2, mem[0xFFFF]=0xA, mem[0x0000]=0xB → mem[0x0100]=0xA, mem[0x0101]=0xB.
- THRESHOLD_EN, threshold=0x80, source words {0x7F, 0x80, 0xFFFFFF00} → destination {0x0, 0xFF, 0x0}.
- Abort in the cycle of word 1's READ, len=4 → exactly one write, no done, IDLE next cycle, and a new start is accepted immediately.
- rst asserted in a WRITE cycle → that write is suppressed, all outputs read 0 the next cycle, and no done pulse occurs.

Source files
------------

// File: rtl/halftone_pkg.sv
// rtl/halftone_pkg.sv - shared types and constants for the halftone datapath
//   state_t         : block-mover sequencer states
//   DEF_ADDR_W      : default data-memory word-address width
//   DEF_DATA_W      : default data-memory word width
//   ZERO_WORD       : all-zero data word
//   PIX_ON / PIX_OFF: binary halftone pixel values
package halftone_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 32;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [31:0] PIX_ON    = 32'h0000_00FF;
    localparam logic [31:0] PIX_OFF   = 32'h0000_0000;

endpackage

// File: rtl/halftone_thresh.sv
// rtl/halftone_thresh.sv - combinational grayscale-to-binary pixel map
//   pixel     in  8       grayscale pixel (low byte of a memory word)
//   threshold in  8       unsigned threshold
//   bin       out DATA_W  PIX_ON when pixel >= threshold, else PIX_OFF
module halftone_thresh
    import halftone_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [7:0]        pixel,
    input  logic [7:0]        threshold,
    output logic [DATA_W-1:0] bin
);

    assign bin = (pixel >= threshold) ? DATA_W'(PIX_ON) : DATA_W'(PIX_OFF);

endmodule

// File: rtl/dm_block_mover.sv
// rtl/dm_block_mover.sv - data-memory block move sequencer (optional THRESHOLD_EN halftone)
//   clk, rst    clock and synchronous active-high reset
//   start       launch request, sampled in IDLE (abort wins)
//   abort       cancel an in-flight move
//   src_addr    first source word address, captured at start
//   dst_addr    first destination word address, captured at start
//   len         word count 0..2^ADDR_W, captured at start
//   threshold   pixel threshold, used only when THRESHOLD_EN is defined
//   busy        high in READ and WRITE
//   done        one-cycle pulse on normal completion
//   dm_read, dm_write, dm_address, dm_wdata, dm_rdata   data-memory master port
// Build option: define THRESHOLD_EN to binarise each word during the move.
module dm_block_mover
    import halftone_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   len,
    input  logic [7:0]        threshold,
    output logic              busy,
    output logic              done,
    output logic              dm_read,
    output logic              dm_write,
    output logic [ADDR_W-1:0] dm_address,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata
);

    state_t            state;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   cnt;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] wdata_f;

`ifdef THRESHOLD_EN
    halftone_thresh #(
        .DATA_W(DATA_W)
    ) u_thresh (
        .pixel    (data_q[7:0]),
        .threshold(threshold),
        .bin      (wdata_f)
    );

    logic unused_data_hi;
    assign unused_data_hi = ^data_q[DATA_W-1:8];
`else
    assign wdata_f = data_q;

    logic unused_threshold;
    assign unused_threshold = ^threshold;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            src_q  <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            cnt    <= '0;
            data_q <= DATA_W'(ZERO_WORD);
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        src_q <= src_addr;
                        dst_q <= dst_addr;
                        len_q <= len;
                        cnt   <= '0;
                        state <= (len == '0) ? DONE : READ;
                    end
                end
                READ: begin
                    data_q <= dm_rdata;
                    state  <= abort ? IDLE : WRITE;
                end
                WRITE: begin
                    cnt <= cnt + 1'b1;
                    if (abort)
                        state <= IDLE;
                    else if ((cnt + 1'b1) == len_q)
                        state <= DONE;
                    else
                        state <= READ;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode from registered state; rst masks them so no access
    // escapes in a reset cycle, even one that lands on a WRITE.
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        dm_read    = 1'b0;
        dm_write   = 1'b0;
        dm_address = '0;
        dm_wdata   = '0;
        if (!rst) begin
            case (state)
                READ: begin
                    busy       = 1'b1;
                    dm_read    = 1'b1;
                    dm_address = src_q + cnt[ADDR_W-1:0];
                end
                WRITE: begin
                    busy       = 1'b1;
                    dm_write   = 1'b1;
                    dm_address = dst_q + cnt[ADDR_W-1:0];
                    dm_wdata   = wdata_f;
                end
                DONE: begin
                    done = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_block_mover.sv
// tb/tb_dm_block_mover.sv - directed self-checking bench for dm_block_mover
module tb_dm_block_mover;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] src_addr;
    logic [15:0] dst_addr;
    logic [16:0] len;
    logic [7:0]  threshold;
    logic        busy;
    logic        done;
    logic        dm_read;
    logic        dm_write;
    logic [15:0] dm_address;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;

    always #5 clk = ~clk;

    dm_block_mover #(
        .ADDR_W(16),
        .DATA_W(32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .threshold (threshold),
        .busy      (busy),
        .done      (done),
        .dm_read   (dm_read),
        .dm_write  (dm_write),
        .dm_address(dm_address),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata)
    );

    logic [31:0] mem [0:65535];
    assign dm_rdata = mem[dm_address];
    always @(posedge clk) if (dm_write) mem[dm_address] <= dm_wdata;

    int errors = 0;
    int checks = 0;
    int done_cyc, done_cnt, busy_cnt, rd_cnt, wr_cnt, both_cnt;
    logic [63:0] pre;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entered at a rising edge with the DUT idle. The start cycle is
    // cycle 0; cycles 1..max_c are observed. abort/rst are asserted for
    // exactly the cycle numbers given (0 = never).
    task automatic run_move(input logic [15:0] s, input logic [15:0] d, input logic [16:0] n,
                            input int abort_c, input int rst_c, input int max_c);
        #1;
        src_addr = s;
        dst_addr = d;
        len      = n;
        start    = 1'b1;
        abort    = 1'b0;
        rst      = 1'b0;
        #1;
        pre = {12'd0, busy, done, dm_read, dm_write, dm_address, dm_wdata};
        done_cyc = -1;
        done_cnt = 0;
        busy_cnt = 0;
        rd_cnt   = 0;
        wr_cnt   = 0;
        both_cnt = 0;
        @(posedge clk);
        for (int c = 1; c <= max_c; c++) begin
            #1;
            start = 1'b0;
            abort = (c == abort_c);
            rst   = (c == rst_c);
            #1;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (dm_read) rd_cnt++;
            if (dm_write) wr_cnt++;
            if (dm_read && dm_write) both_cnt++;
            @(posedge clk);
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 32'h0;
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        src_addr  = '0;
        dst_addr  = '0;
        len       = '0;
        threshold = 8'h80;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("reset_outputs", {busy, done, dm_read, dm_write, dm_address, dm_wdata}, 64'd0);
        rst = 1'b0;
        @(posedge clk);

        // plain copy
        mem[16'h10] = 32'd1; mem[16'h11] = 32'd2; mem[16'h12] = 32'd3; mem[16'h13] = 32'd4;
        run_move(16'h0010, 16'h0040, 17'd4, 0, 0, 10);
        chk("copy_idle_outputs", pre, 64'd0);
        chk("copy_done_cycle", done_cyc, 9);
        chk("copy_done_count", done_cnt, 1);
        chk("copy_busy_cycles", busy_cnt, 8);
        chk("copy_reads", rd_cnt, 4);
        chk("copy_writes", wr_cnt, 4);
        chk("copy_rd_wr_both", both_cnt, 0);
        chk("copy_w0", mem[16'h40], 32'd1);
        chk("copy_w1", mem[16'h41], 32'd2);
        chk("copy_w2", mem[16'h42], 32'd3);
        chk("copy_w3", mem[16'h43], 32'd4);

        // zero length
        mem[16'h50] = 32'h55; mem[16'h60] = 32'h66;
        run_move(16'h0050, 16'h0060, 17'd0, 0, 0, 4);
        chk("len0_done_cycle", done_cyc, 1);
        chk("len0_done_count", done_cnt, 1);
        chk("len0_busy", busy_cnt, 0);
        chk("len0_reads", rd_cnt, 0);
        chk("len0_writes", wr_cnt, 0);
        chk("len0_dst_kept", mem[16'h60], 32'h66);

        // address wrap on source
        mem[16'hFFFF] = 32'hA; mem[16'h0000] = 32'hB;
        run_move(16'hFFFF, 16'h0100, 17'd2, 0, 0, 8);
        chk("wrap_done_cycle", done_cyc, 5);
        chk("wrap_w0", mem[16'h0100], 32'hA);
        chk("wrap_w1", mem[16'h0101], 32'hB);

        // pixel words: binarised with THRESHOLD_EN, verbatim otherwise
        mem[16'h200] = 32'h7F; mem[16'h201] = 32'h80; mem[16'h202] = 32'hFFFF_FF00;
        run_move(16'h0200, 16'h0300, 17'd3, 0, 0, 10);
        chk("pix_done_cycle", done_cyc, 7);
`ifdef THRESHOLD_EN
        chk("pix_w0", mem[16'h300], 32'h0);
        chk("pix_w1", mem[16'h301], 32'hFF);
        chk("pix_w2", mem[16'h302], 32'h0);
`else
        chk("pix_w0", mem[16'h300], 32'h7F);
        chk("pix_w1", mem[16'h301], 32'h80);
        chk("pix_w2", mem[16'h302], 32'hFFFF_FF00);
`endif

        // abort during READ of word 1, then immediate restart
        run_move(16'h0010, 16'h0080, 17'd4, 3, 0, 3);
        chk("abort_writes", wr_cnt, 1);
        chk("abort_reads", rd_cnt, 2);
        chk("abort_no_done", done_cnt, 0);
        run_move(16'h0011, 16'h0090, 17'd2, 0, 0, 8);
        chk("abort_idle_next", pre, 64'd0);
        chk("restart_done_cycle", done_cyc, 5);
        chk("abort_w0", mem[16'h80], 32'd1);
        chk("abort_w1_untouched", mem[16'h81], 32'd0);
        chk("restart_w0", mem[16'h90], 32'd2);
        chk("restart_w1", mem[16'h91], 32'd3);

        // reset in the WRITE cycle of word 1
        run_move(16'h0010, 16'h00A0, 17'd4, 0, 4, 4);
        chk("rst_writes", wr_cnt, 1);
        chk("rst_busy_cycles", busy_cnt, 3);
        chk("rst_no_done", done_cnt, 0);
        run_move(16'h0012, 16'h00B0, 17'd1, 0, 0, 5);
        chk("rst_outputs_after", pre, 64'd0);
        chk("rst_w0", mem[16'hA0], 32'd1);
        chk("rst_w1_suppressed", mem[16'hA1], 32'd0);
        chk("post_rst_done_cycle", done_cyc, 3);
        chk("post_rst_w0", mem[16'hB0], 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
